// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB bridge types: FSM states, default widths, response record
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_m_if.sv
// rtl/apb_m_if.sv - APB master bridge, valid/ready command in, valid/ready response out
// Optional ACCESS-phase timeout abort enabled by APB_M_TIMEOUT_EN.
module apb_m_if
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

`ifdef APB_M_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef APB_M_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
`ifdef APB_M_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = 1'b0;
                    state_d = RESP;
`ifdef APB_M_TIMEOUT_EN
                // The wait cycle that would bring the count to the limit ends the transfer.
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so an async reset drops them at once.
    assign cmd_ready = (state_q == IDLE) && !preset;
    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_m_if.sv
// tb/tb_apb_m_if.sv - directed vector bench for apb_m_if
module tb_apb_m_if;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready;

    int compared = 0;
    int mismatched = 0;

    always #5 pclk = ~pclk;

    apb_m_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic [31:0] exp_pwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Present a command, take the accept edge and check the SETUP cycle.
    task automatic start_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_pwdata);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0; cmd_wdata = 32'h5555_AAAA; cmd_addr = 32'hFFFF_0000;
        chk("setup_psel", 32'(psel), 32'd1);
        chk("setup_penable", 32'(penable), 32'd0);
        chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("setup_paddr", paddr, addr);
        chk("setup_pwrite", 32'(pwrite), 32'(wr));
        chk("setup_pwdata", pwdata, exp_pwdata);
        pready = 1'b1;
        tick();
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 32'hDEAD_C001, 32'h1111_1111, 0, 32'hDEAD_C001, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0001, 32'hC001_DEAF, 32'h2222_2222, 3, 32'hC001_DEAF, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0000, 32'h7777_7777, 32'hDEAD_C001, 0, 32'h0, 32'hDEAD_C001};
        vecs[3] = '{1'b0, 32'h0000_1234, 32'h0BAD_F00D, 32'hA5A5_5A5A, 2, 32'h0, 32'hA5A5_5A5A};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 1, 32'hFFFF_FFFF, 32'h0};

        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        preset = 1'b0;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        rsp_ready = 1'b1;
        tick();
        chk("idle_ignores_rsp_ready", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        for (int v = 0; v < 5; v++) begin
            start_cmd(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_pwdata);
            prdata = vecs[v].prdata;
            for (int i = 0; i <= vecs[v].waits; i++) begin
                pready = (i == vecs[v].waits);
                chk("access_psel", 32'(psel), 32'd1);
                chk("access_penable", 32'(penable), 32'd1);
                chk("access_paddr", paddr, vecs[v].addr);
                chk("access_pwdata", pwdata, vecs[v].exp_pwdata);
                chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
                tick();
            end
            pready = 1'b0; prdata = 32'hBADB_AD00;
            chk("resp_valid", 32'(rsp_valid), 32'd1);
            chk("resp_psel", 32'(psel), 32'd0);
            chk("resp_penable", 32'(penable), 32'd0);
            chk("resp_rdata", rsp_rdata, vecs[v].exp_rdata);
            chk("resp_err", 32'(rsp_err), 32'd0);
            chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("idle_bus_paddr", paddr, vecs[v].addr);
            finish_rsp();
        end

        // Response back-pressure with a second command waiting.
        start_cmd(1'b0, 32'h0000_0040, 32'h0, 32'h0);
        prdata = 32'hCAFE_0042;
        tick();
        prdata = 32'h0;
        pready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0080; cmd_wdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hCAFE_0042);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_psel", 32'(psel), 32'd0);
            chk("bp_paddr", paddr, 32'h0000_0040);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_released_valid", 32'(rsp_valid), 32'd0);
        chk("bp_second_ready", 32'(cmd_ready), 32'd1);
        chk("bp_second_not_yet", 32'(psel), 32'd0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_second_psel", 32'(psel), 32'd1);
        chk("bp_second_paddr", paddr, 32'h0000_0080);
        chk("bp_second_pwdata", pwdata, 32'h1234_5678);
        pready = 1'b1;
        tick(); tick();
        pready = 1'b0;
        chk("bp_second_rsp", 32'(rsp_valid), 32'd1);
        chk("bp_second_rdata", rsp_rdata, 32'h0);
        finish_rsp();

`ifdef APB_M_TIMEOUT_EN
        // Abort after 16 ACCESS cycles with no pready.
        start_cmd(1'b0, 32'h0000_0100, 32'h0, 32'h0);
        pready = 1'b0; prdata = 32'hFEED_BEEF;
        for (int i = 0; i < 16; i++) begin
            chk("to_penable", 32'(penable), 32'd1);
            tick();
        end
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_psel", 32'(psel), 32'd0);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'h0);
        finish_rsp();
        // pready on the 16th cycle completes normally.
        start_cmd(1'b0, 32'h0000_0104, 32'h0, 32'h0);
        prdata = 32'h0000_BEEF;
        for (int i = 0; i < 16; i++) begin
            pready = (i == 15);
            chk("to16_penable", 32'(penable), 32'd1);
            tick();
        end
        pready = 1'b0;
        chk("to16_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to16_rsp_err", 32'(rsp_err), 32'd0);
        chk("to16_rsp_rdata", rsp_rdata, 32'h0000_BEEF);
        finish_rsp();
`else
        // Without the timeout, ACCESS waits as long as pready stays low.
        start_cmd(1'b1, 32'h0000_0100, 32'h0000_00AA, 32'h0000_00AA);
        pready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("nto_penable", 32'(penable), 32'd1);
        chk("nto_rsp_valid", 32'(rsp_valid), 32'd0);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("nto_rsp_valid_done", 32'(rsp_valid), 32'd1);
        chk("nto_rsp_err", 32'(rsp_err), 32'd0);
        finish_rsp();
`endif

        // Asynchronous reset in the middle of ACCESS.
        start_cmd(1'b1, 32'h0000_0200, 32'h0000_0BEE, 32'h0000_0BEE);
        pready = 1'b0;
        tick();
        chk("mid_penable_before", 32'(penable), 32'd1);
        #2 preset = 1'b1;
        #1;
        chk("arst_psel", 32'(psel), 32'd0);
        chk("arst_penable", 32'(penable), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_paddr", paddr, 32'h0);
        pready = 1'b1;
        tick();
        preset = 1'b0;
        pready = 1'b0;
        tick();
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("arst_no_psel", 32'(psel), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
